// File: rtl/foc_pkg.sv
// foc_pkg: shared constants for the FOC current path.
//   GUARD_BITS   : headroom bits added above the sample width inside the Clarke datapath
//   SQRT3_SHIFTS : arithmetic right-shift amounts whose floored sum approximates sqrt(3)
//   mode_e       : per-sample phase mode (MODE_3PH uses ia/ib/ic, MODE_2PH derives ic)
package foc_pkg;

    localparam int GUARD_BITS = 3;
    localparam int N_SHIFTS   = 9;

    // Grouped three at a time into the partial sums of the beta path.
    localparam int SQRT3_SHIFTS [N_SHIFTS] = '{0, 1, 3, 4, 5, 7, 8, 10, 11};

    typedef enum logic {
        MODE_3PH = 1'b0,
        MODE_2PH = 1'b1
    } mode_e;

endpackage

// File: rtl/clark_tr_p_sat_rnd.sv
// sat_rnd: reduces a WI-bit signed value to W bits.
//   Build option CLARK_SAT_EN:
//     defined   -> clamp to [-2^(W-1), 2^(W-1)-1], sat flags a clamp
//     undefined -> keep the low W bits (wrap-around), sat is constant 0
// Ports:
//   din  [WI-1:0] signed input
//   dout [W-1:0]  reduced output
//   sat           1 when dout differs from din because of clamping
module sat_rnd #(
    parameter int WI = 19,
    parameter int W  = 16
) (
    input  logic [WI-1:0] din,
    output logic [W-1:0]  dout,
    output logic          sat
);

`ifdef CLARK_SAT_EN
    // The value fits in W bits exactly when every bit from the W-bit sign
    // position upward agrees with the sign bit.
    logic [WI-W:0] top_bits;
    logic          fits;

    assign top_bits = din[WI-1:W-1];
    assign fits     = (&top_bits) | ~(|top_bits);

    always_comb begin
        dout = din[W-1:0];
        sat  = 1'b0;
        if (!fits) begin
            sat  = 1'b1;
            dout = din[WI-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end
`else
    // Upper bits are deliberately discarded; the reduction keeps them
    // referenced so the wrap is visibly intentional.
    logic unused_hi;

    assign unused_hi = ^din[WI-1:W];
    assign dout      = din[W-1:0];
    assign sat       = 1'b0;
`endif

endmodule

// File: rtl/clark_tr_p.sv
// clark_tr_p: stallable Clarke transform producing the 3x-scaled alpha/beta frame.
//   alpha = 2*ia - (ib + ic)              (3*ia in 2-phase mode)
//   beta  ~ sqrt(3) * (ib - ic)           (sqrt(3) * (ia + 2*ib) in 2-phase mode)
// Build option CLARK_SAT_EN: saturate results to W bits and report o_sat;
// without it results wrap and o_sat stays 0.
// Parameters: W sample width, TW tag width.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_en, i_rdy              input valid / input ready
//   i_mode                   0 = 3-phase, 1 = 2-phase (i_ic ignored)
//   i_ia, i_ib, i_ic, i_tag  input sample and sideband tag
//   o_en, i_ordy             output valid / downstream ready
//   o_ialpha, o_ibeta        results
//   o_tag, o_sat             tag of the output sample, clamp flag
//
// Handshake: a sample moves on a rising edge where its valid is 1 and the
// receiver's ready is 1. The whole pipe advances together (adv) unless the
// output holds a sample the downstream refuses; then every stage, valid bit
// and output freezes, and i_rdy = adv drops so the upstream holds its sample.
// Pipeline: input capture -> S1 (ax2/bmc/bpc) -> S2 (alpha, beta partials) -> output.
module clark_tr_p
    import foc_pkg::*;
#(
    parameter int W  = 16,
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    output logic          i_rdy,
    input  logic          i_mode,
    input  logic [W-1:0]  i_ia,
    input  logic [W-1:0]  i_ib,
    input  logic [W-1:0]  i_ic,
    input  logic [TW-1:0] i_tag,
    output logic          o_en,
    input  logic          i_ordy,
    output logic [W-1:0]  o_ialpha,
    output logic [W-1:0]  o_ibeta,
    output logic [TW-1:0] o_tag,
    output logic          o_sat
);

    localparam int WI = W + GUARD_BITS;

    logic adv;

    // Input capture stage
    logic                 v0;
    logic                 m0;
    logic [TW-1:0]        tag0;
    logic signed [W-1:0]  ia0, ib0, ic0;

    // Stage 1
    logic                 v1;
    logic [TW-1:0]        tag1;
    logic signed [WI-1:0] ax2_1, bmc_1, bpc_1;

    // Stage 2
    logic                 v2;
    logic [TW-1:0]        tag2;
    logic signed [WI-1:0] alpha_2, p0_2, p1_2, p2_2;

    // Combinational values between stages
    logic signed [WI-1:0] ia_x, ib_x, ic_x;
    logic signed [WI-1:0] ax2_c, bmc_c, bpc_c;
    logic signed [WI-1:0] alpha_c, p0_c, p1_c, p2_c;
    logic signed [WI-1:0] beta_c;
    logic [W-1:0]         alpha_w, beta_w;
    logic                 alpha_sat, beta_sat;

    assign adv   = ~(o_en & ~i_ordy);
    assign i_rdy = adv;

    assign ia_x = {{GUARD_BITS{ia0[W-1]}}, ia0};
    assign ib_x = {{GUARD_BITS{ib0[W-1]}}, ib0};
    assign ic_x = {{GUARD_BITS{ic0[W-1]}}, ic0};

    // 2-phase mode substitutes ic = -ia - ib, which folds into the same
    // ax2/bmc/bpc terms so stage 2 needs no knowledge of the mode.
    always_comb begin
        ax2_c = ia_x <<< 1;
        bmc_c = ib_x - ic_x;
        bpc_c = ib_x + ic_x;
        if (m0 == MODE_2PH) begin
            bmc_c = ia_x + (ib_x <<< 1);
            bpc_c = -ia_x;
        end
    end

    // Floored shifts: each term truncates toward -inf, so beta is slightly
    // asymmetric for positive and negative bmc of equal magnitude.
    assign alpha_c = ax2_1 - bpc_1;
    assign p0_c = (bmc_1 >>> SQRT3_SHIFTS[0]) + (bmc_1 >>> SQRT3_SHIFTS[1]) + (bmc_1 >>> SQRT3_SHIFTS[2]);
    assign p1_c = (bmc_1 >>> SQRT3_SHIFTS[3]) + (bmc_1 >>> SQRT3_SHIFTS[4]) + (bmc_1 >>> SQRT3_SHIFTS[5]);
    assign p2_c = (bmc_1 >>> SQRT3_SHIFTS[6]) + (bmc_1 >>> SQRT3_SHIFTS[7]) + (bmc_1 >>> SQRT3_SHIFTS[8]);

    assign beta_c = p0_2 + p1_2 + p2_2;

    sat_rnd #(.WI(WI), .W(W)) u_sat_alpha (
        .din  (alpha_2),
        .dout (alpha_w),
        .sat  (alpha_sat)
    );

    sat_rnd #(.WI(WI), .W(W)) u_sat_beta (
        .din  (beta_c),
        .dout (beta_w),
        .sat  (beta_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            v0       <= 1'b0;
            m0       <= 1'b0;
            tag0     <= '0;
            ia0      <= '0;
            ib0      <= '0;
            ic0      <= '0;
            v1       <= 1'b0;
            tag1     <= '0;
            ax2_1    <= '0;
            bmc_1    <= '0;
            bpc_1    <= '0;
            v2       <= 1'b0;
            tag2     <= '0;
            alpha_2  <= '0;
            p0_2     <= '0;
            p1_2     <= '0;
            p2_2     <= '0;
            o_en     <= 1'b0;
            o_ialpha <= '0;
            o_ibeta  <= '0;
            o_tag    <= '0;
            o_sat    <= 1'b0;
        end else if (adv) begin
            // Data registers load only with a valid sample; bubbles keep the
            // previous contents, so the outputs hold their last result.
            v0 <= i_en;
            if (i_en) begin
                m0   <= i_mode;
                tag0 <= i_tag;
                ia0  <= i_ia;
                ib0  <= i_ib;
                ic0  <= i_ic;
            end

            v1 <= v0;
            if (v0) begin
                tag1  <= tag0;
                ax2_1 <= ax2_c;
                bmc_1 <= bmc_c;
                bpc_1 <= bpc_c;
            end

            v2 <= v1;
            if (v1) begin
                tag2    <= tag1;
                alpha_2 <= alpha_c;
                p0_2    <= p0_c;
                p1_2    <= p1_c;
                p2_2    <= p2_c;
            end

            o_en <= v2;
            if (v2) begin
                o_ialpha <= alpha_w;
                o_ibeta  <= beta_w;
                o_tag    <= tag2;
                o_sat    <= alpha_sat | beta_sat;
            end
        end
    end

endmodule

// File: doc/clark_tr_p.md
# clark_tr_p

Parametrised, stallable Clarke transform for the FOC current path. It sits between the phase-current ADC scaling and the Park transform. It converts phase currents into the 3×-scaled (αβ) frame, using the same shift-add √3 constant as the current fixed block. It adds the following:
- configurable sample width
- a per-sample 2-phase / 3-phase mode
- a sideband tag (motor or channel ID)
- downstream backpressure
- optional output saturation

## Interface
- `W`, default 16: signed sample width of inputs and outputs.
- `TW`, default 4: tag width. The tag is carried unchanged alongside each sample.
- `clk` input, 1 bit: clock. All logic is clocked on the rising edge.
- `rst` input, 1 bit: reset. It is synchronous and active-high, and is the only reset.
- `i_en` input, 1 bit: input sample valid.
- `i_rdy` output, 1 bit: block can accept a sample this cycle.
- `i_mode` input, 1 bit: 0 selects 3-phase (`ia`, `ib`, `ic` used); 1 selects 2-phase (`ic` ignored and taken as −`ia`−`ib`).
- `i_ia`, `i_ib`, `i_ic` input, W bits each: signed phase currents.
- `i_tag` input, TW bits: sideband tag.
- `o_en` output, 1 bit: output valid.
- `i_ordy` input, 1 bit: downstream ready.
- `o_ialpha`, `o_ibeta` output, W bits each: signed α/β results.
- `o_tag` output, TW bits: tag of the output sample.
- `o_sat` output, 1 bit: the output sample was clamped.

## Operation
Internal width is `WI` = W+3; all inputs are sign-extended to WI bits.

**Stage 1 (S1)**
- Mode 0:
  - `ax2` = 2·`ia`
  - `bmc` = `ib` − `ic`
  - `bpc` = `ib` + `ic`
- Mode 1:
  - `ax2` = 2·`ia`
  - `bmc` = `ia` + 2·`ib`
  - `bpc` = −`ia`
- Both modes therefore share the S2 datapath. Mode 1 gives α = 3·`ia`.

**Stage 2 (S2)**
- α = `ax2` − `bpc`.
- β is computed as three partial sums of arithmetic right shifts (floor) of `bmc`:
  - shifts {0, 1, 3}
  - shifts {4, 5, 7}
  - shifts {8, 10, 11}
- Together these approximate √3 ≈ 1.7319.

**Stage 3 (S3 / output)**
- β = sum of the three partials.
- The WI-bit α and β are reduced to W bits (see Configuration).
- The output registers load only on a valid advance. With no new valid sample they hold their last value.

**Sideband and handshake**
- `i_mode` and `i_tag` travel with their sample through every stage.
- Global stall rule: `adv` = ~(`o_en` & ~`i_ordy`), and `i_rdy` = `adv`.
- A sample is accepted when `i_en` & `i_rdy`.
- While `adv` = 0, every stage holds its contents and valid bit.
- `o_en`, `o_ialpha`, `o_ibeta`, `o_tag` and `o_sat` stay stable until `i_ordy` = 1.
- Bubbles are not collapsed while stalled.
- `i_en` while `i_rdy` = 0: the sample is ignored, and the upstream must hold it.

**Reset**
- All valid bits, data registers and outputs go to 0: `o_en`=0, `o_ialpha`=0, `o_ibeta`=0, `o_tag`=0, `o_sat`=0.
- `i_rdy` = 1 in the first cycle after reset.
- Reset asserted mid-stream discards all in-flight samples. Nothing is emitted after reset deasserts.

## Timing
- Latency is 3 cycles: a sample accepted at edge N appears with `o_en`=1 after edge N+3, assuming no stall.
- Throughput is 1 sample per cycle while `i_ordy`=1.
- A stall of k cycles delays every in-flight sample by exactly k cycles.
- Order is preserved. No sample is lost or duplicated.
- `i_rdy` is combinational from `o_en` and `i_ordy`. There is no other combinational input-to-output path.

## Configuration
Macro `CLARK_SAT_EN`:
- **Defined:** α and β are clamped to [−2^(W−1), 2^(W−1)−1]. `o_sat` = 1 for the output sample if either value was clamped.
- **Undefined:** the low W bits are taken (wrap-around), the clamp logic is absent, and `o_sat` is tied to 0.

## Structure
- Package `foc_pkg` holds:
  - `localparam` `SQRT3_SHIFTS` = {0, 1, 3, 4, 5, 7, 8, 10, 11}
  - the mode encoding (`MODE_3PH` = 0, `MODE_2PH` = 1)
  - the guard-bit constant 3
- One sub-module, `sat_rnd`: a WI→W signed clamp plus flag, parametrised on WI and W. It is instanced twice; under `CLARK_SAT_EN` undefined it degenerates to truncation.

## Test plan
All cases use W=16 and `i_ordy`=1 unless stated.
- **Balanced input.** Mode 0, `ia`=1000, `ib`=−500, `ic`=−500, tag 3 → 3 cycles later: `o_en`=1, α=3000, β=0, `o_tag`=3, `o_sat`=0.
- **√3 constant and floor shifts.** Mode 0:
  - `ia`=0, `ib`=1000, `ic`=−1000 → α=0, β=3460.
  - `ib`=−1000, `ic`=1000 → β=−3465.
- **2-phase mode.** Mode 1, `ia`=1000, `ib`=0, `ic`=12345 → α=3000, β=1728; `ic` has no effect.
- **Saturation.** `ia`=20000, `ib`=`ic`=−10000:
  - with `CLARK_SAT_EN` → α=32767, `o_sat`=1;
  - without it → α=−5536, `o_sat`=0.
- **Backpressure.** Stream 5 tagged samples and drop `i_ordy` for 4 cycles once `o_en`=1 → `i_rdy`=0, outputs held stable. On release, all 5 tags emerge in order, each once.
- **Reset mid-stream.** Assert `rst` for 1 cycle with 3 samples in flight → outputs 0, `i_rdy`=1. No `o_en` pulse until a new sample is accepted, which appears 3 cycles after acceptance.
